// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_if
// Description : Instruction-field inputs and datapath control outputs of the
//               multicycle controller, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;

    modport master (
        output op, funct, zero,
        input  alu_control, alu_src_a, alu_src_b, iord, pc_src, pc_en,
               ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
    );

    modport slave (
        input  op, funct, zero,
        output alu_control, alu_src_a, alu_src_b, iord, pc_src, pc_en,
               ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Moore-style multicycle MIPS-subset control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mc_controller_if.slave   bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [2:0] w_funct_ctl;
    logic       w_funct_ok;
    logic [2:0] w_alu_control;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_iord;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_funct_ctl = c_ALU_ADD;
        w_funct_ok  = 1'b1;
        case (bus.funct)
            6'b100000: w_funct_ctl = c_ALU_ADD;
            6'b100010: w_funct_ctl = c_ALU_SUB;
            6'b100100: w_funct_ctl = c_ALU_AND;
            6'b100101: w_funct_ctl = c_ALU_OR;
            6'b101010: w_funct_ctl = c_ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_alu_control = c_ALU_ADD;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_iord        = 1'b0;
        w_pc_src      = 2'b00;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                w_alu_src_b = 2'b11;
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_EXECUTE;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default:          w_illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                w_next      = (r_state == S_ADDIEX) ? S_ADDIWB
                            : (bus.op == c_OP_LW)   ? S_MEMREAD : S_MEMWRITE;
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                w_next = S_MEMWB;
                w_iord = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_next        = S_ALUWB;
                w_alu_src_a   = 1'b1;
                w_alu_control = w_funct_ctl;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = c_ALU_SUB;
                w_pc_src      = 2'b01;
                w_branch      = 1'b1;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write enables are gated by reset so nothing commits while held in reset
    assign bus.pc_en       = rst_n & (w_pc_write | (w_branch & bus.zero));
    assign bus.ir_write    = rst_n & w_ir_write;
    assign bus.mem_write   = rst_n & w_mem_write;
    assign bus.reg_write   = rst_n & w_reg_write;
    assign bus.illegal_op  = rst_n & w_illegal;
    assign bus.alu_control = w_alu_control;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.iord        = w_iord;
    assign bus.pc_src      = w_pc_src;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.mem_to_reg  = w_mem_to_reg;

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; opcode and funct encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  6  opcode field from instruction register.
REQ-005 funct  input  6  funct field from instruction register.
REQ-006 zero  input  1  ALU zero flag (alu_result == 0).
REQ-007 alu_control  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-008 alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 pc_en  output  1  PC load enable.
REQ-013 ir_write, mem_write, reg_write  output  1 each  IR load, memory write and register-file write enables.
REQ-014 reg_dst, mem_to_reg  output  1 each  destination select (1 = rd) and write-back select (1 = memory data).
REQ-015 illegal_op  output  1  unsupported instruction detected.

Function
REQ-016 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-017 Supported R-type funct SHALL be add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-018 The FSM SHALL use a registered state with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-019 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j).
REQ-020 Further transitions: MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-021 MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP SHALL each return to FETCH.
REQ-022 Instruction latencies SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-023 Outputs SHALL be Moore decodes of state, except pc_en; any output not listed for a state SHALL be 0, and alu_control SHALL default to 010.
REQ-024 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, ir_write=1, and pc_write=1.
REQ-025 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_control=010 (branch target precompute).
REQ-026 MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_control=010.
REQ-027 MEMREAD SHALL drive iord=1; MEMWRITE SHALL drive iord=1, mem_write=1.
REQ-028 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0; ADDIWB SHALL drive reg_write=1, mem_to_reg=0, reg_dst=0.
REQ-029 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, with alu_control decoded from funct per REQ-007/017; ALUWB SHALL drive reg_write=1, reg_dst=1.
REQ-030 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, and internal branch=1.
REQ-031 JUMP SHALL drive pc_src=10 and pc_write=1.
REQ-032 pc_en SHALL equal pc_write OR (branch AND zero), combinationally, within the same cycle.
REQ-033 In DECODE, an unsupported op, or op=000000 with unsupported funct, SHALL assert illegal_op for that cycle; next state SHALL be FETCH, with no register or memory write.
REQ-034 illegal_op SHALL be 0 in every other state.

Reset
REQ-035 rst_n low SHALL force state to FETCH immediately, independent of clk.
REQ-036 While rst_n is low, pc_en, ir_write, mem_write, reg_write and illegal_op SHALL be forced 0.
REQ-037 While rst_n is low, other outputs SHALL show FETCH values.
REQ-038 Reset asserted in any state, including mid-instruction, SHALL abandon the instruction with no further write.
REQ-039 The first rising edge after rst_n rises SHALL complete a FETCH cycle, with ir_write=1 and pc_en=1.

Verification
REQ-040 Reset then release -> cycle 0 shows ir_write=1, pc_en=1, alu_src_b=01, alu_control=010; next cycle is DECODE with alu_src_b=11.
REQ-041 lw (op=100011) -> 5 cycles: FETCH, DECODE, MEMADR, MEMREAD (iord=1), MEMWB (reg_write=1, mem_to_reg=1); then back in FETCH.
REQ-042 beq with zero=1 in BRANCH -> pc_en=1, pc_src=01, alu_control=110; repeat with zero=0 -> pc_en=0; both cases reach FETCH after 3 cycles.
REQ-043 R-type with funct=101010 -> EXECUTE alu_control=111, ALUWB reg_write=1, reg_dst=1; cover all five funct codes.
REQ-044 op=111111, and separately op=000000 with funct=000111 -> illegal_op=1 in DECODE only, next state FETCH, reg_write and mem_write never 1.
REQ-045 sw, with rst_n pulsed low during MEMADR -> mem_write never asserted; FETCH outputs after release.
